// File: rtl/dice_pkg.sv
// Shared types and constants for the dice demo controller and its button front end.
package dice_pkg;

  localparam int DICE_W     = 3;
  localparam int ROLL_CNT_W = 8;

  localparam logic [DICE_W-1:0] DICE_BLANK = 3'd0;

  typedef enum logic [1:0] {
    IDLE,
    SPIN,
    SETTLE,
    SHOW
  } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Push-button front end: two-flop synchronizer, counter debouncer and a
// single-cycle pulse on the debounced rising edge.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1250000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
      press   <= 1'b0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
      press   <= 1'b0;
      // Any sample that agrees with the accepted level restarts the count.
      if (sync_p1 != level) begin
        if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          level <= sync_p1;
          cnt   <= '0;
          press <= sync_p1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/dice_roll_ctrl.sv
// Dice demo sequencer: free-runs the roller while idle, plays a decelerating
// spin of roll pulses on a button press, then latches and shows the final face.
module dice_roll_ctrl
  import dice_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1250000,
  parameter int SPIN_STEPS      = 12,
  parameter int BASE_INTERVAL   = 6250000,
  parameter int INTERVAL_INC    = 1250000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn_raw,
  input  logic [DICE_W-1:0]     dice_in,
  output logic                  roll,
  output logic [DICE_W-1:0]     display,
  output logic                  busy,
  output logic                  done,
  output logic [ROLL_CNT_W-1:0] roll_count
);

  localparam int ICNT_W = $clog2(BASE_INTERVAL + SPIN_STEPS * INTERVAL_INC + 1);
  localparam int STEP_W = $clog2(SPIN_STEPS + 1);

  state_t              state;
  logic [ICNT_W-1:0]   icnt;
  logic [STEP_W-1:0]   step;
  logic [STEP_W-1:0]   step_nxt;
  logic [ICNT_W-1:0]   reload;
  logic                spin_pulse;
  logic                pulse_p1;
  logic                level;
  logic                press;
  logic                start;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btn_raw),
    .level  (level),
    .press  (press)
  );

  // press and level rise on the same edge, so this is just the press pulse.
  assign start      = press && level;
  assign spin_pulse = (state == SPIN) && (icnt == ICNT_W'(1));
  assign step_nxt   = step + 1'b1;
  assign reload     = ICNT_W'(BASE_INTERVAL + int'(step_nxt) * INTERVAL_INC);

  always_comb begin
    roll = (state == IDLE) || (state == SHOW) || spin_pulse;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      icnt       <= '0;
      step       <= '0;
      pulse_p1   <= 1'b0;
      display    <= DICE_BLANK;
      busy       <= 1'b0;
      done       <= 1'b0;
      roll_count <= '0;
    end else begin
      done     <= 1'b0;
      // The roller output reflects a pulse one cycle later; capture it then.
      pulse_p1 <= spin_pulse;
      unique case (state)
        IDLE, SHOW: begin
          if (start) begin
            state <= SPIN;
            icnt  <= ICNT_W'(BASE_INTERVAL);
            step  <= '0;
            busy  <= 1'b1;
          end
        end
        SPIN: begin
          if (pulse_p1) begin
            display <= dice_in;
          end
          if (spin_pulse) begin
            step <= step_nxt;
            if (step_nxt == STEP_W'(SPIN_STEPS)) begin
              state <= SETTLE;
            end else begin
              icnt <= reload;
            end
          end else begin
            icnt <= icnt - 1'b1;
          end
        end
        SETTLE: begin
          display    <= dice_in;
          done       <= 1'b1;
          busy       <= 1'b0;
          roll_count <= roll_count + 8'd1;
          state      <= SHOW;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// Directed bench for dice_roll_ctrl driving a simple 1..6 stepping roller.
module tb_dice_roll_ctrl;

  localparam int DEB  = 4;
  localparam int STEPS = 3;
  localparam int BASE = 2;
  localparam int INC  = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_raw = 1'b0;
  logic [2:0] face;
  logic       roll;
  logic [2:0] display;
  logic       busy;
  logic       done;
  logic [7:0] roll_count;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_cnt = 8'd0;
  logic [2:0] prev_disp = 3'd0;

  always #5 clk = ~clk;

  dice_roll_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .SPIN_STEPS     (STEPS),
    .BASE_INTERVAL  (BASE),
    .INTERVAL_INC   (INC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .dice_in   (face),
    .roll      (roll),
    .display   (display),
    .busy      (busy),
    .done      (done),
    .roll_count(roll_count)
  );

  // Dice roller: advances 1..6 on every roll-enabled cycle.
  always_ff @(posedge clk) begin
    if (rst) face <= 3'd1;
    else if (roll) face <= (face == 3'd6) ? 3'd1 : face + 3'd1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One full press/spin/settle sequence checked cycle by cycle against a
  // scoreboard of expected pulse times and display capture times.
  task automatic press_spin(input bit repress);
    int         pq[$];
    int         dq[$];
    int         p;
    int         last;
    bit         exp_roll;
    logic [2:0] fin;
    p = 0;
    for (int k = 0; k < STEPS; k++) begin
      p += BASE + k * INC;
      pq.push_back(p);
    end
    last = p;
    fin  = 3'd0;
    btn_raw = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("pre_busy", 32'(busy), 32'd0);
      chk("pre_roll", 32'(roll), 32'd1);
    end
    tick();
    for (int idx = 0; idx <= last + 6; idx++) begin
      if (idx > 0) tick();
      if (idx == 0 || idx >= last + 2) exp_roll = 1'b1;
      else exp_roll = (pq.size() > 0 && pq[0] == idx);
      chk("roll", 32'(roll), 32'(exp_roll));
      if (idx >= 1 && idx <= last && pq.size() > 0 && pq[0] == idx) begin
        void'(pq.pop_front());
        dq.push_back(idx + 2);
      end
      if (dq.size() > 0 && dq[0] == idx) begin
        chk("disp_upd", 32'(display), 32'(face));
        void'(dq.pop_front());
      end
      if (idx == 1) chk("disp_hold", 32'(display), 32'(prev_disp));
      chk("busy", 32'(busy), 32'(idx >= 1 && idx <= last + 1));
      chk("done", 32'(done), 32'(idx == last + 2));
      if (idx == last + 1) fin = face;
      if (idx == last + 2) begin
        exp_cnt = exp_cnt + 8'd1;
        chk("roll_count", 32'(roll_count), 32'(exp_cnt));
      end
      if (idx == last + 5) begin
        chk("disp_final", 32'(display), 32'(fin));
        chk("disp_nonzero", 32'(display != 3'd0), 32'd1);
      end
      if (idx == 0) btn_raw = 1'b0;
      if (repress && idx == 4) btn_raw = 1'b1;
    end
    chk("pq_empty", 32'(pq.size()), 32'd0);
    if (repress) begin
      btn_raw = 1'b0;
      for (int i = 0; i < 8; i++) begin
        tick();
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_cnt", 32'(roll_count), 32'(exp_cnt));
      end
    end
    prev_disp = fin;
  endtask

  initial begin
    // Reset and idle free-run.
    rst = 1'b1;
    btn_raw = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_disp", 32'(display), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_roll", 32'(roll), 32'd1);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_cnt", 32'(roll_count), 32'd0);
    end

    // Three-cycle glitch is one short of the debounce window.
    btn_raw = 1'b1;
    tick();
    tick();
    tick();
    btn_raw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("glitch_busy", 32'(busy), 32'd0);
      chk("glitch_roll", 32'(roll), 32'd1);
    end

    press_spin(1'b0);
    press_spin(1'b1);

    // Reset between the first and second spin pulses.
    btn_raw = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    for (int i = 0; i < 3; i++) tick();
    chk("abort_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    btn_raw = 1'b0;
    tick();
    rst = 1'b0;
    exp_cnt = 8'd0;
    prev_disp = 3'd0;
    chk("abort_disp", 32'(display), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_roll", 32'(roll), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_cnt", 32'(roll_count), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("abort_idle_busy", 32'(busy), 32'd0);
      chk("abort_idle_done", 32'(done), 32'd0);
    end

    // 256 rolls wrap the counter back to zero.
    for (int r = 0; r < 256; r++) press_spin(1'b0);
    chk("wrap_cnt", 32'(roll_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
